// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - 2R1W register file with busy scoreboard and debug tap
// Optional write-through forwarding on the read ports: define REGFILE_BYPASS_EN.
module reg_file_sb #(
  parameter int ADDRESS_WIDTH = 5,
  parameter int DATA_WIDTH    = 32,
  parameter int DEBUG_REG     = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] AD1,
  input  logic [ADDRESS_WIDTH-1:0] AD2,
  output logic [DATA_WIDTH-1:0]    RD1,
  output logic [DATA_WIDTH-1:0]    RD2,
  output logic                     BUSY1,
  output logic                     BUSY2,
  input  logic [ADDRESS_WIDTH-1:0] AD3,
  input  logic                     WE3,
  input  logic [DATA_WIDTH-1:0]    WD3,
  input  logic                     ISSUE_EN,
  input  logic [ADDRESS_WIDTH-1:0] ISSUE_AD,
  output logic [ADDRESS_WIDTH:0]   PENDING,
  output logic [DATA_WIDTH-1:0]    a0
);

  localparam int NUM_REGS = 1 << ADDRESS_WIDTH;
  localparam int PW       = ADDRESS_WIDTH + 1;
  localparam logic [ADDRESS_WIDTH-1:0] DBG_IDX = ADDRESS_WIDTH'(DEBUG_REG);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   busy;
  logic [NUM_REGS-1:0]   busy_next;
  logic [PW-1:0]         pending_q;
  logic                  wb_valid;
  logic                  iss_valid;
  logic                  inc;
  logic                  dec;
  logic                  hit1;
  logic                  hit2;

  assign wb_valid  = WE3 && (AD3 != '0);
  assign iss_valid = ISSUE_EN && (ISSUE_AD != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[AD3] <= WD3;
    end
  end

  // Issue is applied after writeback so a newer producer on the same register wins.
  always_comb begin
    busy_next = busy;
    if (wb_valid) begin
      busy_next[AD3] = 1'b0;
    end
    if (iss_valid) begin
      busy_next[ISSUE_AD] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_comb begin
    inc = iss_valid && !busy[ISSUE_AD];
    dec = wb_valid && busy[AD3] && !(iss_valid && (ISSUE_AD == AD3));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= '0;
      pending_q <= '0;
    end else begin
      busy      <= busy_next;
      pending_q <= pending_q + PW'(inc) - PW'(dec);
    end
  end

`ifdef REGFILE_BYPASS_EN
  assign hit1 = !rst && WE3 && (AD3 == AD1) && (AD1 != '0);
  assign hit2 = !rst && WE3 && (AD3 == AD2) && (AD2 != '0);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  always_comb begin
    if (hit1) begin
      RD1 = WD3;
    end else if (AD1 == '0) begin
      RD1 = '0;
    end else begin
      RD1 = regs[AD1];
    end
    if (hit2) begin
      RD2 = WD3;
    end else if (AD2 == '0) begin
      RD2 = '0;
    end else begin
      RD2 = regs[AD2];
    end
  end

  assign BUSY1   = busy[AD1] && !hit1;
  assign BUSY2   = busy[AD2] && !hit2;
  assign PENDING = pending_q;
  assign a0      = regs[DBG_IDX];

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - scoreboard bench for reg_file_sb with directed vectors
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  AD1, AD2, AD3, ISSUE_AD;
  logic        WE3, ISSUE_EN;
  logic [31:0] WD3;
  logic [31:0] RD1, RD2, a0;
  logic        BUSY1, BUSY2;
  logic [5:0]  PENDING;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  localparam int S_RD1 = 0, S_RD2 = 1, S_B1 = 2, S_B2 = 3, S_PEND = 4, S_A0 = 5;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  reg_file_sb dut (
    .clk(clk), .rst(rst),
    .AD1(AD1), .AD2(AD2), .RD1(RD1), .RD2(RD2),
    .BUSY1(BUSY1), .BUSY2(BUSY2),
    .AD3(AD3), .WE3(WE3), .WD3(WD3),
    .ISSUE_EN(ISSUE_EN), .ISSUE_AD(ISSUE_AD),
    .PENDING(PENDING), .a0(a0)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] observe(int sel);
    case (sel)
      S_RD1:   return RD1;
      S_RD2:   return RD2;
      S_B1:    return {31'd0, BUSY1};
      S_B2:    return {31'd0, BUSY2};
      S_PEND:  return {26'd0, PENDING};
      default: return a0;
    endcase
  endfunction

  // Monitor: drains pending expectations once outputs have settled.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      wait (exp_q.size() != 0);
      #1;
      while (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        act = observe(e.sel);
        n_cmp++;
        if (act !== e.val) begin
          n_err++;
          $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.val);
        end
      end
    end
  end

  task automatic expect_out(input string name, input int sel, input logic [31:0] val);
    exp_t e;
    e.name = name;
    e.sel  = sel;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic settle();
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      #1;
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL settle: %0d checks left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic cyc(input logic we, input logic [4:0] ad3, input logic [31:0] wd3,
                     input logic iss, input logic [4:0] iss_ad);
    @(negedge clk);
    WE3      = we;
    AD3      = ad3;
    WD3      = wd3;
    ISSUE_EN = iss;
    ISSUE_AD = iss_ad;
  endtask

  task automatic idle();
    cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  initial begin
    rst = 1'b1;
    AD1 = 5'd5; AD2 = 5'd0; AD3 = 5'd0; WE3 = 1'b0; WD3 = '0;
    ISSUE_EN = 1'b0; ISSUE_AD = 5'd0;
    #3;
    expect_out("reset_init_rd1", S_RD1, 32'd0);
    expect_out("reset_init_pending", S_PEND, 32'd0);
    settle();
    @(negedge clk);
    rst = 1'b0;

    // Preload reg 5 and reg 10, leave reg 9 busy, then reset mid-cycle.
    cyc(1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd9);
    cyc(1'b1, 5'd10, 32'h77, 1'b0, 5'd0);
    idle();
    AD1 = 5'd5;
    expect_out("preload_rd1", S_RD1, 32'hDEADBEEF);
    expect_out("preload_a0", S_A0, 32'h77);
    expect_out("preload_pending", S_PEND, 32'd1);
    settle();
    #1 rst = 1'b1;
    expect_out("async_reset_rd1", S_RD1, 32'd0);
    expect_out("async_reset_a0", S_A0, 32'd0);
    expect_out("async_reset_pending", S_PEND, 32'd0);
    settle();
    rst = 1'b0;

    // Register 0 ignores writes and issues.
    cyc(1'b1, 5'd0, 32'h1234, 1'b1, 5'd0);
    AD1 = 5'd0;
    expect_out("zero_busy1", S_B1, 32'd0);
    settle();
    idle();
    expect_out("zero_rd1", S_RD1, 32'd0);
    expect_out("zero_pending", S_PEND, 32'd0);
    settle();

    cyc(1'b1, 5'd10, 32'h2A, 1'b0, 5'd0);
    idle();
    AD2 = 5'd10;
    expect_out("write_rd2", S_RD2, 32'h2A);
    expect_out("debug_a0", S_A0, 32'h2A);
    settle();

    // Forwarding: reg 7 holds 0x11 and is busy when 0x55 is written back.
    cyc(1'b1, 5'd7, 32'h11, 1'b0, 5'd0);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
    cyc(1'b1, 5'd7, 32'h55, 1'b0, 5'd0);
    AD1 = 5'd7;
`ifdef REGFILE_BYPASS_EN
    expect_out("fwd_rd1_same_cycle", S_RD1, 32'h55);
    expect_out("fwd_busy1_same_cycle", S_B1, 32'd0);
`else
    expect_out("fwd_rd1_same_cycle", S_RD1, 32'h11);
    expect_out("fwd_busy1_same_cycle", S_B1, 32'd1);
`endif
    expect_out("fwd_pending_same_cycle", S_PEND, 32'd1);
    settle();
    idle();
    expect_out("fwd_rd1_next", S_RD1, 32'h55);
    expect_out("fwd_busy1_next", S_B1, 32'd0);
    expect_out("fwd_pending_next", S_PEND, 32'd0);
    settle();

    // Scoreboard corner cases.
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    idle();
    AD1 = 5'd3; AD2 = 5'd4;
    expect_out("sb_pending2", S_PEND, 32'd2);
    expect_out("sb_busy1_r3", S_B1, 32'd1);
    expect_out("sb_busy2_r4", S_B2, 32'd1);
    settle();
    cyc(1'b1, 5'd3, 32'h33, 1'b0, 5'd0);
    idle();
    expect_out("sb_wb3_pending", S_PEND, 32'd1);
    expect_out("sb_wb3_busy1", S_B1, 32'd0);
    expect_out("sb_wb3_rd1", S_RD1, 32'h33);
    settle();
    cyc(1'b1, 5'd4, 32'h44, 1'b1, 5'd4);
    idle();
    expect_out("sb_same_reg_busy2", S_B2, 32'd1);
    expect_out("sb_same_reg_pending", S_PEND, 32'd1);
    expect_out("sb_same_reg_rd2", S_RD2, 32'h44);
    settle();
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd4);
    idle();
    expect_out("sb_reissue_pending", S_PEND, 32'd1);
    settle();
    cyc(1'b1, 5'd4, 32'h45, 1'b1, 5'd6);
    idle();
    AD1 = 5'd6;
    expect_out("sb_swap_pending", S_PEND, 32'd1);
    expect_out("sb_swap_busy2_r4", S_B2, 32'd0);
    expect_out("sb_swap_busy1_r6", S_B1, 32'd1);
    settle();
    cyc(1'b1, 5'd6, 32'h66, 1'b0, 5'd0);
    cyc(1'b1, 5'd6, 32'h67, 1'b0, 5'd0);
    idle();
    expect_out("sb_idle_wb_pending", S_PEND, 32'd0);
    expect_out("sb_idle_wb_busy1", S_B1, 32'd0);
    expect_out("sb_idle_wb_rd1", S_RD1, 32'h67);
    settle();

    // Counter range: fill then drain all registers 1..31.
    for (int i = 1; i < 32; i++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'(i));
    end
    idle();
    AD1 = 5'd31; AD2 = 5'd0;
    expect_out("full_pending", S_PEND, 32'd31);
    expect_out("full_busy1_r31", S_B1, 32'd1);
    expect_out("full_busy2_r0", S_B2, 32'd0);
    settle();
    for (int i = 1; i < 32; i++) begin
      cyc(1'b1, 5'(i), 32'(i * 3), 1'b0, 5'd0);
    end
    idle();
    AD2 = 5'd1;
    expect_out("drain_pending", S_PEND, 32'd0);
    expect_out("drain_rd1_r31", S_RD1, 32'd93);
    expect_out("drain_rd2_r1", S_RD2, 32'd3);
    expect_out("drain_a0", S_A0, 32'd30);
    settle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation time exceeded, expected completion");
    $fatal(1);
  end

endmodule
